// File: rtl/spi_regbank_if.sv
// SPI pin bundle for spi_regbank: the bench drives it as master, the
// register bank consumes it as slave.
interface spi_regbank_if;
  logic CEB;
  logic SCLK;
  logic MOSI;
  logic MISO;
  logic MISO_EN;

  modport master (output CEB, output SCLK, output MOSI, input MISO, input MISO_EN);
  modport slave  (input CEB, input SCLK, input MOSI, output MISO, output MISO_EN);
endinterface

// File: rtl/spi_regbank.sv
// spi_regbank: oversampled SPI (mode 0) slave with an addressed,
// auto-incrementing word protocol. Writable control words drive R; reads
// return R words, then RD status words, then zero.
// Optional macro SPI_SNAPSHOT_EN: capture the whole RD vector when a read
// command completes, so every word of that burst is coherent.
module spi_regbank #(
  parameter int DW  = 8,
  parameter int NWR = 8,
  parameter int NRD = 8,
  parameter int AW  = 7,
  parameter logic [NWR*DW-1:0] R_RST = '0
) (
  input  logic              CLK,
  input  logic              RST,
  spi_regbank_if.slave      spi,
  output logic [NWR*DW-1:0] R,
  input  logic [NRD*DW-1:0] RD,
  output logic [NWR-1:0]    WR_STROBE,
  output logic              FRAME_ERR
);

  localparam int CMDW = AW + 1;
  // Shift-in register only keeps the bits preceding the one being sampled.
  localparam int SHW  = ((CMDW > DW) ? CMDW : DW) - 1;
  localparam int CW   = $clog2(SHW + 2);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CMD   = 2'd1;
  localparam logic [1:0] S_WDATA = 2'd2;
  localparam logic [1:0] S_RDATA = 2'd3;

  logic              ceb_meta_q, ceb_sync_q, ceb_prev_q;
  logic              sclk_meta_q, sclk_sync_q, sclk_prev_q;
  logic              mosi_meta_q, mosi_sync_q;
  logic              ceb_fall, ceb_rise, sclk_rise, sclk_fall;

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [SHW-1:0]    shift_in_q, shift_in_d;
  logic [DW-2:0]     sh_out_q, sh_out_d;
  logic [NWR*DW-1:0] r_q, r_d;
  logic [NWR-1:0]    wr_strobe_q, wr_strobe_d;
  logic              frame_err_q, frame_err_d;
  logic              miso_q, miso_d;
  logic              miso_en_q, miso_en_d;
  logic [CMDW-1:0]   cmd_word;
  logic [DW-1:0]     data_word;
  logic [DW-1:0]     rd_word;
  logic [NRD*DW-1:0] rd_src;

`ifdef SPI_SNAPSHOT_EN
  logic [NRD*DW-1:0] snap_q, snap_d;
  assign rd_src = snap_q;
`else
  assign rd_src = RD;
`endif

  // CEB synchroniser resets to "low" so a CEB held low through reset never
  // looks like a fresh falling edge; the frame restarts only on a real one.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ceb_meta_q <= 1'b0;
      ceb_sync_q <= 1'b0;
      ceb_prev_q <= 1'b0;
    end else begin
      ceb_meta_q <= spi.CEB;
      ceb_sync_q <= ceb_meta_q;
      ceb_prev_q <= ceb_sync_q;
    end
  end

  // SCLK/MOSI synchronisers; edges only matter inside a frame, so no reset.
  always_ff @(posedge CLK) begin
    sclk_meta_q <= spi.SCLK;
    sclk_sync_q <= sclk_meta_q;
    sclk_prev_q <= sclk_sync_q;
    mosi_meta_q <= spi.MOSI;
    mosi_sync_q <= mosi_meta_q;
  end

  assign ceb_fall  = ceb_prev_q & ~ceb_sync_q;
  assign ceb_rise  = ~ceb_prev_q & ceb_sync_q;
  assign sclk_rise = sclk_sync_q & ~sclk_prev_q;
  assign sclk_fall = ~sclk_sync_q & sclk_prev_q;

  // Read word selection: R words, then RD words, then zero.
  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NWR; k++)
      if (int'(addr_q) == k) rd_word = r_q[k*DW +: DW];
    for (int j = 0; j < NRD; j++)
      if (int'(addr_q) == NWR + j) rd_word = rd_src[j*DW +: DW];
  end

  // Frame FSM: command decode, write commit, read shift-out.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    addr_d      = addr_q;
    shift_in_d  = shift_in_q;
    sh_out_d    = sh_out_q;
    r_d         = r_q;
    wr_strobe_d = '0;
    frame_err_d = frame_err_q;
    miso_d      = miso_q;
    miso_en_d   = miso_en_q;
`ifdef SPI_SNAPSHOT_EN
    snap_d      = snap_q;
`endif
    cmd_word    = {shift_in_q[CMDW-2:0], mosi_sync_q};
    data_word   = {shift_in_q[DW-2:0], mosi_sync_q};

    if (ceb_rise) begin
      // Ending with a partial word drops it and flags the frame.
      if (state_q != S_IDLE && bit_cnt_q != '0) frame_err_d = 1'b1;
      state_d   = S_IDLE;
      bit_cnt_d = '0;
      miso_d    = 1'b0;
      miso_en_d = 1'b0;
    end else if (ceb_fall) begin
      state_d     = S_CMD;
      bit_cnt_d   = '0;
      frame_err_d = 1'b0;
      miso_d      = 1'b0;
      miso_en_d   = 1'b1;
    end else begin
      case (state_q)
        S_CMD: begin
          miso_d = 1'b0;
          if (sclk_rise) begin
            shift_in_d = {shift_in_q[SHW-2:0], mosi_sync_q};
            if (bit_cnt_q == CW'(CMDW - 1)) begin
              bit_cnt_d = '0;
              addr_d    = cmd_word[AW-1:0];
              if (cmd_word[AW]) begin
                state_d = S_WDATA;
              end else begin
                state_d = S_RDATA;
`ifdef SPI_SNAPSHOT_EN
                snap_d  = RD;
`endif
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
        S_WDATA: begin
          miso_d = 1'b0;
          if (sclk_rise) begin
            shift_in_d = {shift_in_q[SHW-2:0], mosi_sync_q};
            if (bit_cnt_q == CW'(DW - 1)) begin
              bit_cnt_d = '0;
              for (int k = 0; k < NWR; k++) begin
                if (int'(addr_q) == k) begin
                  r_d[k*DW +: DW] = data_word;
                  wr_strobe_d[k]  = 1'b1;
                end
              end
              addr_d = addr_q + 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
        S_RDATA: begin
          if (sclk_fall) begin
            if (bit_cnt_q == '0) begin
              miso_d   = rd_word[DW-1];
              sh_out_d = rd_word[DW-2:0];
            end else begin
              miso_d   = sh_out_q[DW-2];
              sh_out_d = {sh_out_q[DW-3:0], 1'b0};
            end
          end
          if (sclk_rise) begin
            if (bit_cnt_q == CW'(DW - 1)) begin
              bit_cnt_d = '0;
              addr_d    = addr_q + 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
        default: miso_d = 1'b0;
      endcase
    end
  end

  // Control and register-bank state with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      addr_q      <= '0;
      r_q         <= R_RST;
      wr_strobe_q <= '0;
      frame_err_q <= 1'b0;
      miso_q      <= 1'b0;
      miso_en_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      addr_q      <= addr_d;
      r_q         <= r_d;
      wr_strobe_q <= wr_strobe_d;
      frame_err_q <= frame_err_d;
      miso_q      <= miso_d;
      miso_en_q   <= miso_en_d;
    end
  end

  // Shift registers carry data only; they are reloaded before every use.
  always_ff @(posedge CLK) begin
    shift_in_q <= shift_in_d;
    sh_out_q   <= sh_out_d;
`ifdef SPI_SNAPSHOT_EN
    snap_q     <= snap_d;
`endif
  end

  assign R           = r_q;
  assign WR_STROBE   = wr_strobe_q;
  assign FRAME_ERR   = frame_err_q;
  assign spi.MISO    = miso_q;
  assign spi.MISO_EN = miso_en_q;

endmodule

// File: tb/tb_spi_regbank.sv
// Self-checking bench for spi_regbank: directed scenarios plus randomized
// write/read frames checked against a word-level register model.
module tb_spi_regbank;
  localparam int DW  = 8;
  localparam int NWR = 8;
  localparam int NRD = 8;
  localparam int AW  = 7;

  logic              CLK = 1'b0;
  logic              RST;
  logic [NWR*DW-1:0] R;
  logic [NRD*DW-1:0] RD;
  logic [NWR-1:0]    WR_STROBE;
  logic              FRAME_ERR;

  spi_regbank_if sif();

  spi_regbank #(.DW(DW), .NWR(NWR), .NRD(NRD), .AW(AW)) dut (
    .CLK(CLK), .RST(RST), .spi(sif), .R(R), .RD(RD),
    .WR_STROBE(WR_STROBE), .FRAME_ERR(FRAME_ERR)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  logic [7:0] model_r [NWR];
  logic [7:0] rd_w    [NRD];
  logic [NWR-1:0] strobe_log [$];

  always_comb begin
    RD = '0;
    for (int j = 0; j < NRD; j++) RD[j*8 +: 8] = rd_w[j];
  end

  always @(negedge CLK) if (WR_STROBE != '0) strobe_log.push_back(WR_STROBE);

  function automatic logic [NWR*8-1:0] model_vec();
    logic [NWR*8-1:0] v;
    for (int k = 0; k < NWR; k++) v[k*8 +: 8] = model_r[k];
    return v;
  endfunction

  function automatic logic [7:0] model_read(input int a);
    if (a < NWR) return model_r[a];
    if (a < NWR + NRD) return rd_w[a-NWR];
    return 8'h00;
  endfunction

  task automatic clk_wait(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic spi_begin();
    sif.CEB = 1'b0;
    clk_wait(4);
  endtask

  task automatic spi_end();
    clk_wait(4);
    sif.CEB = 1'b1;
    clk_wait(6);
  endtask

  // Clocks nbits of tx (MSB first); MISO is sampled as SCLK rises.
  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      sif.MOSI = tx[7-i];
      clk_wait(4);
      rx = {rx[6:0], sif.MISO};
      sif.SCLK = 1'b1;
      clk_wait(4);
      sif.SCLK = 1'b0;
    end
  endtask

  task automatic do_write(input int a0, input int n, input logic [31:0] data);
    logic [7:0] rx;
    int a;
    spi_begin();
    spi_bits(8'h80 | 8'(a0), 8, rx);
    a = a0;
    for (int i = 0; i < n; i++) begin
      spi_bits(data[8*i +: 8], 8, rx);
      if (a < NWR) model_r[a] = data[8*i +: 8];
      a = (a + 1) % 128;
    end
    spi_end();
  endtask

  task automatic do_read(input int a0, input int n, output logic [31:0] got);
    logic [7:0] rx;
    got = '0;
    spi_begin();
    spi_bits(8'(a0) & 8'h7F, 8, rx);
    for (int i = 0; i < n; i++) begin
      spi_bits(8'h00, 8, rx);
      got[8*i +: 8] = rx;
    end
    spi_end();
  endtask

  task automatic test_reset();
    sif.CEB = 1'b1; sif.SCLK = 1'b0; sif.MOSI = 1'b0;
    RST = 1'b1;
    clk_wait(2);
    RST = 1'b0;
    for (int k = 0; k < NWR; k++) model_r[k] = 8'h00;
    clk_wait(1);
    total++; if (R !== {NWR*8{1'b0}}) begin bad++; $display("FAIL reset_R got=%h want=0", R); end
    total++; if (WR_STROBE !== '0) begin bad++; $display("FAIL reset_strobe got=%b want=0", WR_STROBE); end
    total++; if (sif.MISO_EN !== 1'b0) begin bad++; $display("FAIL reset_miso_en got=%b want=0", sif.MISO_EN); end
    total++; if (FRAME_ERR !== 1'b0) begin bad++; $display("FAIL reset_frame_err got=%b want=0", FRAME_ERR); end
    total++; if (sif.MISO !== 1'b0) begin bad++; $display("FAIL reset_miso got=%b want=0", sif.MISO); end
    clk_wait(6);
    total++; if (sif.MISO_EN !== 1'b0) begin bad++; $display("FAIL idle_miso_en got=%b want=0", sif.MISO_EN); end
  endtask

  task automatic test_burst_write();
    strobe_log.delete();
    do_write(2, 2, 32'h0000_C35A);
    total++; if (R[2*8 +: 8] !== 8'h5A) begin bad++; $display("FAIL bw_word2 got=%h want=5a", R[2*8 +: 8]); end
    total++; if (R[3*8 +: 8] !== 8'hC3) begin bad++; $display("FAIL bw_word3 got=%h want=c3", R[3*8 +: 8]); end
    total++; if (R !== model_vec()) begin bad++; $display("FAIL bw_all got=%h want=%h", R, model_vec()); end
    total++; if (strobe_log.size() != 2) begin bad++; $display("FAIL bw_strobe_count got=%0d want=2", strobe_log.size()); end
    else begin
      total++; if (strobe_log[0] !== 8'h04 || strobe_log[1] !== 8'h08) begin
        bad++; $display("FAIL bw_strobe_seq got=%h,%h want=04,08", strobe_log[0], strobe_log[1]);
      end
    end
  endtask

  task automatic test_burst_read();
    logic [31:0] got;
    rd_w[0] = 8'hAA; rd_w[1] = 8'h55;
    do_read(8, 2, got);
    total++; if (got[7:0] !== 8'hAA) begin bad++; $display("FAIL br_word0 got=%h want=aa", got[7:0]); end
    total++; if (got[15:8] !== 8'h55) begin bad++; $display("FAIL br_word1 got=%h want=55", got[15:8]); end
    total++; if (FRAME_ERR !== 1'b0) begin bad++; $display("FAIL br_frame_err got=%b want=0", FRAME_ERR); end
  endtask

  task automatic test_wrap();
    logic [31:0] got;
    strobe_log.delete();
    do_write(127, 2, 32'h0000_2211);
    total++; if (R[7:0] !== 8'h22) begin bad++; $display("FAIL wrap_word0 got=%h want=22", R[7:0]); end
    total++; if (R !== model_vec()) begin bad++; $display("FAIL wrap_all got=%h want=%h", R, model_vec()); end
    total++; if (strobe_log.size() != 1) begin bad++; $display("FAIL wrap_strobe_count got=%0d want=1", strobe_log.size()); end
    else begin
      total++; if (strobe_log[0] !== 8'h01) begin bad++; $display("FAIL wrap_strobe got=%h want=01", strobe_log[0]); end
    end
    do_read(20, 1, got);
    total++; if (got[7:0] !== 8'h00) begin bad++; $display("FAIL oor_read got=%h want=00", got[7:0]); end
  endtask

  task automatic test_abort();
    logic [7:0] rx;
    strobe_log.delete();
    spi_begin();
    spi_bits(8'h81, 8, rx);
    spi_bits(8'hFF, 5, rx);
    spi_end();
    total++; if (R !== model_vec()) begin bad++; $display("FAIL abort_R got=%h want=%h", R, model_vec()); end
    total++; if (strobe_log.size() != 0) begin bad++; $display("FAIL abort_strobe got=%0d want=0", strobe_log.size()); end
    total++; if (FRAME_ERR !== 1'b1) begin bad++; $display("FAIL abort_frame_err got=%b want=1", FRAME_ERR); end
    sif.CEB = 1'b0;
    clk_wait(6);
    total++; if (FRAME_ERR !== 1'b0) begin bad++; $display("FAIL abort_clear got=%b want=0", FRAME_ERR); end
    total++; if (sif.MISO_EN !== 1'b1) begin bad++; $display("FAIL frame_miso_en got=%b want=1", sif.MISO_EN); end
    spi_end();
    total++; if (FRAME_ERR !== 1'b0) begin bad++; $display("FAIL empty_frame_err got=%b want=0", FRAME_ERR); end
  endtask

  task automatic test_snapshot();
    logic [7:0] a, b, w1;
    logic [7:0] exp1;
    rd_w[0] = 8'hAA; rd_w[1] = 8'h55;
`ifdef SPI_SNAPSHOT_EN
    exp1 = 8'h55;
`else
    exp1 = 8'h77;
`endif
    spi_begin();
    spi_bits(8'h08, 8, a);
    spi_bits(8'h00, 3, a);
    rd_w[1] = 8'h77;
    spi_bits(8'h00, 5, b);
    spi_bits(8'h00, 8, w1);
    spi_end();
    total++; if ({a[2:0], b[4:0]} !== 8'hAA) begin bad++; $display("FAIL snap_word0 got=%h want=aa", {a[2:0], b[4:0]}); end
    total++; if (w1 !== exp1) begin bad++; $display("FAIL snap_word1 got=%h want=%h", w1, exp1); end
  endtask

  task automatic test_rst_midframe();
    logic [7:0] rx;
    strobe_log.delete();
    spi_begin();
    spi_bits(8'h80, 8, rx);
    spi_bits(8'hF0, 4, rx);
    RST = 1'b1;
    clk_wait(2);
    RST = 1'b0;
    for (int k = 0; k < NWR; k++) model_r[k] = 8'h00;
    spi_bits(8'hAB, 8, rx);
    total++; if (sif.MISO_EN !== 1'b0) begin bad++; $display("FAIL rstmid_miso_en got=%b want=0", sif.MISO_EN); end
    spi_end();
    total++; if (R !== model_vec()) begin bad++; $display("FAIL rstmid_R got=%h want=%h", R, model_vec()); end
    total++; if (strobe_log.size() != 0) begin bad++; $display("FAIL rstmid_strobe got=%0d want=0", strobe_log.size()); end
    total++; if (FRAME_ERR !== 1'b0) begin bad++; $display("FAIL rstmid_frame_err got=%b want=0", FRAME_ERR); end
  endtask

  task automatic test_random();
    logic [31:0] got;
    int a0, n;
    for (int it = 0; it < 24; it++) begin
      a0 = ($urandom_range(0, 4) == 0) ? int'($urandom_range(124, 127)) : int'($urandom_range(0, 19));
      n  = $urandom_range(1, 4);
      if ($urandom_range(0, 1) == 1) begin
        do_write(a0, n, $urandom);
        total++; if (R !== model_vec()) begin bad++; $display("FAIL rand_write it=%0d got=%h want=%h", it, R, model_vec()); end
      end else begin
        for (int j = 0; j < NRD; j++) rd_w[j] = 8'($urandom);
        do_read(a0, n, got);
        for (int i = 0; i < n; i++) begin
          total++;
          if (got[8*i +: 8] !== model_read((a0 + i) % 128)) begin
            bad++; $display("FAIL rand_read it=%0d addr=%0d got=%h want=%h", it, (a0 + i) % 128, got[8*i +: 8], model_read((a0 + i) % 128));
          end
        end
      end
    end
  endtask

  initial begin
    for (int j = 0; j < NRD; j++) rd_w[j] = 8'h00;
    test_reset();
    test_burst_write();
    test_burst_read();
    test_wrap();
    test_abort();
    test_snapshot();
    test_rst_midframe();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
